lfsr_seq_monitor: RTL and testbench

//  Parametrised Fibonacci LFSR, serial pattern detector and detection counter in one block.

---
 rtl/lfsr_seq_monitor_pkg.sv | 38 +++
 rtl/lfsr_seq_monitor_seq_match_fsm.sv | 87 ++++++++
 rtl/lfsr_seq_monitor.sv | 96 +++++++++
 tb/tb_lfsr_seq_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_monitor_pkg.sv
`default_nettype none
// ============================================================================
// lfsr_seq_monitor_pkg: shared state encoding and maximal-length tap masks.
// Revision: 1.0
// ============================================================================
package lfsr_seq_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } seq_state_e;

   localparam logic [31:0] TAPS_W4  = 32'h0000_000C;
   localparam logic [31:0] TAPS_W22 = 32'h0030_0000;

   // Maximal-length Fibonacci masks (bit k set means q[k] feeds the XOR).
   function automatic logic [31:0] default_taps(input int width);
      logic [31:0] taps;
      taps = 32'h0;
      case (width)
         3:       taps = 32'h0000_0006;
         4:       taps = TAPS_W4;
         5:       taps = 32'h0000_0014;
         6:       taps = 32'h0000_0030;
         7:       taps = 32'h0000_0060;
         8:       taps = 32'h0000_00B8;
         16:      taps = 32'h0000_B400;
         22:      taps = TAPS_W22;
         24:      taps = 32'h00E1_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0;
      endcase
      return taps;
   endfunction

endpackage : lfsr_seq_monitor_pkg
`default_nettype wire

// File: rtl/lfsr_seq_monitor_seq_match_fsm.sv
`default_nettype none
// ============================================================================
// seq_match_fsm: shift history, fill-tracking FSM, pattern pulse, saturating count.
// Revision: 1.0
// ============================================================================
module seq_match_fsm
   import lfsr_seq_monitor_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1111,
   parameter int                 CNT_W   = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             restart,
   input  logic             cnt_clr,
   input  logic             b,
   output logic             seq_detected,
   output logic [CNT_W-1:0] det_count
);

   localparam int                FILL_W    = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   seq_state_e           state, state_nx;
   logic [PAT_LEN-2:0]   hist, hist_nx;
   logic [FILL_W-1:0]    fill, fill_nx;
   logic [PAT_LEN-1:0]   window;
   logic                 match;
   logic [CNT_W-1:0]     count_nx;

   assign window = {hist, b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         hist         <= '0;
         fill         <= '0;
         seq_detected <= 1'b0;
         det_count    <= '0;
      end else begin
         state        <= state_nx;
         hist         <= hist_nx;
         fill         <= fill_nx;
         seq_detected <= match;
         det_count    <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      hist_nx  = hist;
      fill_nx  = fill;
      match    = 1'b0;
      count_nx = det_count;

      if (restart) begin
         state_nx = IDLE;
         hist_nx  = '0;
         fill_nx  = '0;
      end else if (step) begin
         hist_nx = window[PAT_LEN-2:0];
         // A match needs a full window: RUN, or the step that completes FILL.
         match = (window == PATTERN) &&
                 ((state == RUN) || ((state == FILL) && (fill == FILL_LAST)));
         case (state)
            IDLE: begin
               state_nx = FILL;
               fill_nx  = FILL_W'(1);
            end
            FILL: begin
               if (fill == FILL_LAST) state_nx = RUN;
               else                   fill_nx  = fill + 1'b1;
            end
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
         endcase
      end

      if (cnt_clr)                          count_nx = '0;
      else if (match && det_count != CNT_MAX) count_nx = det_count + 1'b1;
   end

endmodule : seq_match_fsm
`default_nettype wire

// File: rtl/lfsr_seq_monitor.sv
`default_nettype none
// ============================================================================
// lfsr_seq_monitor: Fibonacci LFSR with serial pattern detector and detection
// counter. Optional run-time seed load when LFSR_SEED_LOAD_EN is defined.
// Revision: 1.0
// ============================================================================
module lfsr_seq_monitor
   import lfsr_seq_monitor_pkg::*;
#(
   parameter int                 WIDTH   = 22,
   parameter logic [WIDTH-1:0]   TAPS    = 22'h300000,
   parameter logic [WIDTH-1:0]   SEED    = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1111,
   parameter int                 CNT_W   = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sh_en,
   input  logic             cnt_clr,
`ifdef LFSR_SEED_LOAD_EN
   input  logic             seed_ld,
   input  logic [WIDTH-1:0] seed_in,
`endif
   output logic [WIDTH-1:0] lfsr_out,
   output logic             lfsr_msb,
   output logic             max_tick,
   output logic             seq_detected,
   output logic [CNT_W-1:0] det_count
);

   logic [WIDTH-1:0] q, q_next, q_d, seed_ref;
   logic             step, restart, b;

   assign b      = q[WIDTH-1];
   assign q_next = {q[WIDTH-2:0], ^(q & TAPS)};

`ifdef LFSR_SEED_LOAD_EN
   logic [WIDTH-1:0] load_val;

   // A zero seed would lock the register up, so fall back to SEED.
   assign load_val = (seed_in == '0) ? SEED : seed_in;
   assign restart  = seed_ld;
   assign step     = sh_en & ~seed_ld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       seed_ref <= SEED;
      else if (seed_ld) seed_ref <= load_val;
   end

   always_comb begin
      q_d = q;
      if (seed_ld)   q_d = load_val;
      else if (step) q_d = q_next;
   end
`else
   assign restart  = 1'b0;
   assign step     = sh_en;
   assign seed_ref = SEED;

   always_comb begin
      q_d = q;
      if (step) q_d = q_next;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q        <= SEED;
         max_tick <= 1'b0;
      end else begin
         q        <= q_d;
         max_tick <= step && (q_next == seed_ref);
      end
   end

   seq_match_fsm #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .CNT_W   (CNT_W)
   ) u_seq_match_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .step         (step),
      .restart      (restart),
      .cnt_clr      (cnt_clr),
      .b            (b),
      .seq_detected (seq_detected),
      .det_count    (det_count)
   );

   assign lfsr_out = q;
   assign lfsr_msb = q[WIDTH-1];

endmodule : lfsr_seq_monitor
`default_nettype wire

// File: tb/tb_lfsr_seq_monitor.sv
`default_nettype none
// ============================================================================
// tb_lfsr_seq_monitor: randomized and directed checks against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_lfsr_seq_monitor;

   localparam int         WIDTH   = 4;
   localparam logic [3:0] TAPS    = 4'hC;
   localparam logic [3:0] SEED    = 4'h1;
   localparam int         PAT_LEN = 4;
   localparam logic [3:0] PATTERN = 4'b1111;
   localparam int         CNT_W   = 2;
   localparam int         CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sh_en = 1'b0;
   logic             cnt_clr = 1'b0;
   logic [WIDTH-1:0] lfsr_out;
   logic             lfsr_msb;
   logic             max_tick;
   logic             seq_detected;
   logic [CNT_W-1:0] det_count;
`ifdef LFSR_SEED_LOAD_EN
   logic             seed_ld = 1'b0;
   logic [WIDTH-1:0] seed_in = '0;
`endif

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   int m_q;
   bit m_hist[$];
   int m_cnt;
   bit m_det;
   bit m_tick;

   always #5 clk = ~clk;

   lfsr_seq_monitor #(
      .WIDTH   (WIDTH),
      .TAPS    (TAPS),
      .SEED    (SEED),
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sh_en        (sh_en),
      .cnt_clr      (cnt_clr),
`ifdef LFSR_SEED_LOAD_EN
      .seed_ld      (seed_ld),
      .seed_in      (seed_in),
`endif
      .lfsr_out     (lfsr_out),
      .lfsr_msb     (lfsr_msb),
      .max_tick     (max_tick),
      .seq_detected (seq_detected),
      .det_count    (det_count)
   );

   task automatic model_reset();
      m_q = SEED;
      m_hist.delete();
      m_cnt  = 0;
      m_det  = 1'b0;
      m_tick = 1'b0;
   endtask

   task automatic model_step(input bit sh, input bit clr);
      bit b;
      int fb;
      int v;
      m_det  = 1'b0;
      m_tick = 1'b0;
      if (sh) begin
         b   = ((m_q >> (WIDTH - 1)) & 1) != 0;
         fb  = $countones(m_q & int'(TAPS)) % 2;
         m_q = ((m_q * 2) % (1 << WIDTH)) + fb;
         m_hist.push_back(b);
         if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
         if (m_hist.size() == PAT_LEN) begin
            v = 0;
            foreach (m_hist[i]) v = v * 2 + int'(m_hist[i]);
            m_det = (v == int'(PATTERN));
         end
         m_tick = (m_q == int'(SEED));
      end
      if (clr)                          m_cnt = 0;
      else if (m_det && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
   endtask

   // One clock: drive, take the edge, sample 1 time unit later, advance model.
   task automatic cycle(input bit sh, input bit clr);
      sh_en   = sh;
      cnt_clr = clr;
      @(posedge clk);
      #1;
      model_step(sh, clr);
      sh_en   = 1'b0;
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sh_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (lfsr_out !== SEED) begin
         errors++; $display("FAIL reset_lfsr_out: got %h want %h", lfsr_out, SEED);
      end
      checks++;
      if (max_tick !== 1'b0 || seq_detected !== 1'b0) begin
         errors++; $display("FAIL reset_pulses: got tick=%b det=%b want 0 0", max_tick, seq_detected);
      end
      checks++;
      if (det_count !== '0) begin
         errors++; $display("FAIL reset_det_count: got %0d want 0", det_count);
      end
      rst_n = 1'b1;
      sh_en = 1'b0;
      model_reset();
   endtask

   task automatic test_sequence();
      logic [3:0] exp_seq [15];
      int pulses;
      exp_seq = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                  4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (lfsr_out !== exp_seq[i % 15] || lfsr_out !== 4'(m_q)) begin
            errors++; $display("FAIL seq_lfsr_out step %0d: got %h want %h", i + 1, lfsr_out, exp_seq[i % 15]);
         end
         checks++;
         if (lfsr_msb !== lfsr_out[WIDTH-1]) begin
            errors++; $display("FAIL seq_lfsr_msb step %0d: got %b want %b", i + 1, lfsr_msb, lfsr_out[WIDTH-1]);
         end
         checks++;
         if (max_tick !== (i == 14 || i == 29) || max_tick !== m_tick) begin
            errors++; $display("FAIL seq_max_tick step %0d: got %b want %b", i + 1, max_tick, m_tick);
         end
         checks++;
         if (seq_detected !== m_det || seq_detected !== max_tick) begin
            errors++; $display("FAIL seq_detected step %0d: got %b want %b", i + 1, seq_detected, m_det);
         end
         checks++;
         if (det_count !== CNT_W'(m_cnt)) begin
            errors++; $display("FAIL seq_det_count step %0d: got %0d want %0d", i + 1, det_count, m_cnt);
         end
         if (seq_detected === 1'b1) pulses++;
      end
      checks++;
      if (det_count !== 2'd2 || pulses != 2) begin
         errors++; $display("FAIL seq_count_after_30: got %0d (pulses %0d) want 2", det_count, pulses);
      end
   endtask

   task automatic test_saturation();
      for (int i = 30; i < 75; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (det_count !== CNT_W'(m_cnt) || seq_detected !== m_det) begin
            errors++; $display("FAIL sat_step %0d: got cnt=%0d det=%b want cnt=%0d det=%b",
                               i + 1, det_count, seq_detected, m_cnt, m_det);
         end
      end
      checks++;
      if (det_count !== 2'd3) begin
         errors++; $display("FAIL sat_final: got %0d want 3", det_count);
      end
   endtask

   task automatic test_cnt_clr();
      test_reset();
      repeat (14) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      checks++;
      if (det_count !== 2'd0 || m_cnt != 0) begin
         errors++; $display("FAIL clr_same_cycle: got %0d want 0", det_count);
      end
      repeat (14) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      checks++;
      if (seq_detected !== 1'b1 || det_count !== 2'd1) begin
         errors++; $display("FAIL clr_next_detect: got det=%b cnt=%0d want 1 1", seq_detected, det_count);
      end
      cycle(1'b0, 1'b1);
      checks++;
      if (det_count !== 2'd0) begin
         errors++; $display("FAIL clr_while_idle: got %0d want 0", det_count);
      end
   endtask

   task automatic test_toggle();
      test_reset();
      for (int i = 0; i < 64; i++) begin
         cycle(i % 2 == 0, 1'b0);
         checks++;
         if (lfsr_out !== 4'(m_q) || max_tick !== m_tick || seq_detected !== m_det ||
             det_count !== CNT_W'(m_cnt)) begin
            errors++; $display("FAIL toggle cycle %0d: got q=%h t=%b d=%b c=%0d want q=%h t=%b d=%b c=%0d",
                               i, lfsr_out, max_tick, seq_detected, det_count, 4'(m_q), m_tick, m_det, m_cnt);
         end
         if (i % 2 == 1) begin
            checks++;
            if (max_tick !== 1'b0 || seq_detected !== 1'b0) begin
               errors++; $display("FAIL toggle_hold_pulse cycle %0d: got t=%b d=%b want 0 0", i, max_tick, seq_detected);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      test_reset();
      repeat (13) cycle(1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (lfsr_out !== SEED || det_count !== '0 || seq_detected !== 1'b0) begin
         errors++; $display("FAIL midreset_async: got q=%h cnt=%0d det=%b want 1 0 0", lfsr_out, det_count, seq_detected);
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 15; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (seq_detected !== (i == 14) || seq_detected !== m_det) begin
            errors++; $display("FAIL midreset_detect step %0d: got %b want %b", i + 1, seq_detected, m_det);
         end
      end
`ifdef LFSR_SEED_LOAD_EN
      seed_ld = 1'b1;
      seed_in = '0;
      cycle(1'b1, 1'b0);
      seed_ld = 1'b0;
      model_reset();
      checks++;
      if (lfsr_out !== SEED || max_tick !== 1'b0 || seq_detected !== 1'b0) begin
         errors++; $display("FAIL seed_ld_zero: got q=%h t=%b d=%b want 1 0 0", lfsr_out, max_tick, seq_detected);
      end
      m_cnt = int'(det_count);
`endif
   endtask

   task automatic test_random();
      bit sh;
      bit clr;
      test_reset();
      for (int i = 0; i < 400; i++) begin
         sh  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 31) == 0);
         cycle(sh, clr);
         checks++;
         if (lfsr_out !== 4'(m_q) || max_tick !== m_tick || seq_detected !== m_det ||
             det_count !== CNT_W'(m_cnt)) begin
            errors++; $display("FAIL random cycle %0d: got q=%h t=%b d=%b c=%0d want q=%h t=%b d=%b c=%0d",
                               i, lfsr_out, max_tick, seq_detected, det_count, 4'(m_q), m_tick, m_det, m_cnt);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sequence();
      test_saturation();
      test_cnt_clr();
      test_toggle();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_lfsr_seq_monitor
`default_nettype wire
